// File: rtl/mso_trigger_pkg.sv
//------------------------------------------------------------------------------
// mso_trigger_pkg : capture state encoding shared by the trigger hub and host
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mso_trigger_pkg;

    localparam int ST_W = 2;

    // Encoding is visible to host status logic; all four codes are live states.
    typedef enum logic [ST_W-1:0] {
        ST_DISARMED  = 2'b00,
        ST_ARMED     = 2'b01,
        ST_TRIGGERED = 2'b10,
        ST_CLEARED   = 2'b11
    } trig_state_t;

endpackage : mso_trigger_pkg

`default_nettype wire

// File: rtl/mso_trigger_hub_rise_detect.sv
//------------------------------------------------------------------------------
// rise_detect : 1-bit rising-edge detector with registered history
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic rise_o
);

    logic d_q;

    // History clears to 0, so a high input on the first cycle out of reset is a rise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d_i;
        end
    end

    assign rise_o = d_i & ~d_q;

endmodule : rise_detect

`default_nettype wire

// File: rtl/mso_trigger_hub.sv
//------------------------------------------------------------------------------
// mso_trigger_hub : masked trigger combiner driving the capture state machine
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mso_trigger_hub
    import mso_trigger_pkg::*;
#(
    parameter int NUM_TRIGGERS = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    arm,
    input  logic                    reset,
    input  logic [NUM_TRIGGERS-1:0] triggers,
    input  logic [NUM_TRIGGERS-1:0] mask,
    output logic [ST_W-1:0]         trigger_state
);

    trig_state_t state_q;
    trig_state_t state_d;
    logic        arm_rise;
    logic        hit;

    rise_detect u_arm_rise (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (arm),
        .rise_o (arm_rise)
    );

    assign hit = |(triggers & mask);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_DISARMED;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_DISARMED: begin
                if (arm_rise) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                // A held arm vetoes disarm so the host cannot race itself.
                if (reset && !arm) state_d = ST_DISARMED;
                else if (hit)      state_d = ST_TRIGGERED;
            end
            ST_TRIGGERED: begin
                if (reset)     state_d = ST_DISARMED;
                else if (!hit) state_d = ST_CLEARED;
            end
            ST_CLEARED: begin
                if (reset) state_d = ST_DISARMED;
            end
            default: state_d = ST_DISARMED;
        endcase
    end

    assign trigger_state = state_q;

endmodule : mso_trigger_hub

`default_nettype wire

// File: tb/tb_mso_trigger_hub.sv
//------------------------------------------------------------------------------
// tb_mso_trigger_hub : directed self-checking bench for mso_trigger_hub
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mso_trigger_hub;

    localparam int NT = 4;

    logic          clk;
    logic          rst_n;
    logic          arm;
    logic          reset;
    logic [NT-1:0] triggers;
    logic [NT-1:0] mask;
    logic [1:0]    trigger_state;

    int checks;
    int errors;

    mso_trigger_hub #(.NUM_TRIGGERS(NT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .arm           (arm),
        .reset         (reset),
        .triggers      (triggers),
        .mask          (mask),
        .trigger_state (trigger_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; arm = 1'b0; reset = 1'b0; triggers = '0; mask = 4'hF;
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (trigger_state !== 2'b00) begin
            errors++; $display("FAIL in_reset: got %b expected %b", trigger_state, 2'b00);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (trigger_state !== 2'b00) begin
            errors++; $display("FAIL after_release: got %b expected %b", trigger_state, 2'b00);
        end
        arm = 1'b1;
        tick();
        checks++;
        if (trigger_state !== 2'b01) begin
            errors++; $display("FAIL arm_pulse: got %b expected %b", trigger_state, 2'b01);
        end
        arm = 1'b0;
        tick(); tick();
        checks++;
        if (trigger_state !== 2'b01) begin
            errors++; $display("FAIL armed_hold: got %b expected %b", trigger_state, 2'b01);
        end
    endtask

    task automatic test_disarm();
        reset = 1'b1;
        tick();
        checks++;
        if (trigger_state !== 2'b00) begin
            errors++; $display("FAIL disarm: got %b expected %b", trigger_state, 2'b00);
        end
        reset = 1'b0; triggers = 4'b0001;
        tick(); tick();
        checks++;
        if (trigger_state !== 2'b00) begin
            errors++; $display("FAIL disarmed_ignores_trig: got %b expected %b", trigger_state, 2'b00);
        end
        triggers = '0;
    endtask

    task automatic test_arm_veto();
        arm = 1'b1;
        tick();
        checks++;
        if (trigger_state !== 2'b01) begin
            errors++; $display("FAIL rearm: got %b expected %b", trigger_state, 2'b01);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (trigger_state !== 2'b01) begin
            errors++; $display("FAIL arm_veto: got %b expected %b", trigger_state, 2'b01);
        end
        reset = 1'b0; triggers = 4'b0001;
        tick();
        checks++;
        if (trigger_state !== 2'b10) begin
            errors++; $display("FAIL triggered: got %b expected %b", trigger_state, 2'b10);
        end
    endtask

    task automatic test_clear_reset();
        triggers = '0;
        tick();
        checks++;
        if (trigger_state !== 2'b11) begin
            errors++; $display("FAIL cleared: got %b expected %b", trigger_state, 2'b11);
        end
        triggers = 4'b0001;
        tick();
        checks++;
        if (trigger_state !== 2'b11) begin
            errors++; $display("FAIL cleared_ignores_trig: got %b expected %b", trigger_state, 2'b11);
        end
        triggers = '0; reset = 1'b1;
        tick();
        checks++;
        if (trigger_state !== 2'b00) begin
            errors++; $display("FAIL cleared_reset_arm_high: got %b expected %b", trigger_state, 2'b00);
        end
        reset = 1'b0;
        tick(); tick();
        checks++;
        if (trigger_state !== 2'b00) begin
            errors++; $display("FAIL no_level_rearm: got %b expected %b", trigger_state, 2'b00);
        end
    endtask

    task automatic test_mask();
        arm = 1'b0;
        tick();
        arm = 1'b1;
        tick();
        checks++;
        if (trigger_state !== 2'b01) begin
            errors++; $display("FAIL mask_arm: got %b expected %b", trigger_state, 2'b01);
        end
        arm = 1'b0; mask = 4'b0100; triggers = 4'b1011;
        tick(); tick();
        checks++;
        if (trigger_state !== 2'b01) begin
            errors++; $display("FAIL masked_out: got %b expected %b", trigger_state, 2'b01);
        end
        triggers = 4'b0100;
        tick();
        checks++;
        if (trigger_state !== 2'b10) begin
            errors++; $display("FAIL masked_in: got %b expected %b", trigger_state, 2'b10);
        end
        triggers = '0;
        tick();
        checks++;
        if (trigger_state !== 2'b11) begin
            errors++; $display("FAIL one_cycle_pulse_clear: got %b expected %b", trigger_state, 2'b11);
        end
    endtask

    task automatic test_mid_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0; arm = 1'b1; mask = 4'hF;
        tick();
        triggers = 4'b1000;
        tick();
        checks++;
        if (trigger_state !== 2'b10) begin
            errors++; $display("FAIL mid_pre_trig: got %b expected %b", trigger_state, 2'b10);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if (trigger_state !== 2'b00) begin
            errors++; $display("FAIL mid_reset: got %b expected %b", trigger_state, 2'b00);
        end
        triggers = '0;
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (trigger_state !== 2'b01) begin
            errors++; $display("FAIL arm_held_release: got %b expected %b", trigger_state, 2'b01);
        end
        tick();
        checks++;
        if (trigger_state !== 2'b01) begin
            errors++; $display("FAIL arm_held_stay: got %b expected %b", trigger_state, 2'b01);
        end
    endtask

    task automatic test_back_to_back();
        // Hit already present when arming: ARMED then TRIGGERED on the next clock.
        arm = 1'b0; reset = 1'b1;
        tick();
        checks++;
        if (trigger_state !== 2'b00) begin
            errors++; $display("FAIL b2b_disarm: got %b expected %b", trigger_state, 2'b00);
        end
        reset = 1'b0; triggers = 4'b0010; arm = 1'b1;
        tick();
        checks++;
        if (trigger_state !== 2'b01) begin
            errors++; $display("FAIL hit_on_arm_a: got %b expected %b", trigger_state, 2'b01);
        end
        tick();
        checks++;
        if (trigger_state !== 2'b10) begin
            errors++; $display("FAIL hit_on_arm_b: got %b expected %b", trigger_state, 2'b10);
        end
        triggers = '0; arm = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0; arm = 1'b1; mask = '0; triggers = 4'hF;
        tick(); tick();
        checks++;
        if (trigger_state !== 2'b01) begin
            errors++; $display("FAIL mask_zero: got %b expected %b", trigger_state, 2'b01);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        #2;
        test_reset();
        test_disarm();
        test_arm_veto();
        test_clear_reset();
        test_mask();
        test_mid_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mso_trigger_hub

`default_nettype wire
